// File: rtl/byte_serial_add_ctrl_if.sv
// Handshake and data bundle for the byte-serial adder: operand request side and result side.
interface byte_serial_add_ctrl_if #(
    parameter int NBYTES = 4
);
    logic                  in_val;
    logic                  in_rdy;
    logic [8*NBYTES-1:0]   in0;
    logic [8*NBYTES-1:0]   in1;
    logic                  cin;
    logic                  out_val;
    logic                  out_rdy;
    logic [8*NBYTES-1:0]   out;
    logic                  cout;
    logic                  ovf;

    modport master (
        output in_val, in0, in1, cin, out_rdy,
        input  in_rdy, out_val, out, cout, ovf
    );

    modport slave (
        input  in_val, in0, in1, cin, out_rdy,
        output in_rdy, out_val, out, cout, ovf
    );
endinterface

// File: rtl/byte_serial_add_ctrl.sv
// Wide add-with-carry built from one 8-bit adder slice stepped LSB byte first,
// with val/rdy handshakes on the operand and result sides.
module byte_serial_add_ctrl #(
    parameter int NBYTES = 4
) (
    input logic                  clk,
    input logic                  reset,
    byte_serial_add_ctrl_if.slave bus
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     out_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             in_rdy_q;
    logic             out_val_q;
    logic             cout_q;
    logic             ovf_q;

    logic [31:0]      bit_base;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [8:0]       slice_sum;

    // The single shared 8-bit slice, steered by the byte index.
    always_comb begin
        bit_base  = 32'(idx_q) << 3;
        a_byte    = a_q[bit_base +: 8];
        b_byte    = b_q[bit_base +: 8];
        slice_sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
    end

    // NOTE: every register here uses non-blocking assignment so all state
    // advances together on the edge; the operand registers are reset too,
    // which keeps the slice inputs defined straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            out_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_val) begin
                        a_q      <= bus.in0;
                        b_q      <= bus.in1;
                        carry_q  <= bus.cin;
                        idx_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    out_q[bit_base +: 8] <= slice_sum[7:0];
                    carry_q              <= slice_sum[8];
                    idx_q                <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Top byte: its slice sees the operand sign bits directly.
                        cout_q    <= slice_sum[8];
                        ovf_q     <= (a_byte[7] == b_byte[7]) && (slice_sum[7] != a_byte[7]);
                        idx_q     <= '0;
                        out_val_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        out_val_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_val_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_val = out_val_q;
    assign bus.out     = out_q;
    assign bus.cout    = cout_q;
    assign bus.ovf     = ovf_q;
endmodule
